// File: rtl/inner_product_acc_if.sv
// rtl/inner_product_acc_if.sv - controller-side handshake bundle for inner_product_acc
interface inner_product_acc_if #(
    parameter int number_of_elements = 4
);
    logic                            start;
    logic                            acc_en;
    logic [32*number_of_elements-1:0] In1;
    logic [32*number_of_elements-1:0] In2;
    logic                            busy;
    logic [31:0]                     out;
    logic                            out_stb;
    logic                            out_ack;

    modport master (
        output start, acc_en, In1, In2, out_ack,
        input  busy, out, out_stb
    );

    modport slave (
        input  start, acc_en, In1, In2, out_ack,
        output busy, out, out_stb
    );
endinterface

// File: rtl/inner_product_acc.sv
// rtl/inner_product_acc.sv - single-precision dot product with optional chaining onto the previous result
module fp_unit #(
    parameter bit IS_ADD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        a_stb,
    input  logic        b_stb,
    output logic        a_ack,
    output logic        b_ack,
    output logic [31:0] z,
    output logic        z_stb,
    input  logic        z_ack
);
    localparam logic [1:0] U_IDLE = 2'd0, U_CALC = 2'd1, U_OUT = 2'd2;

    logic [1:0]  st_q, st_d;
    logic [31:0] opa_q, opa_d, opb_q, opb_d, z_q, z_d;
    logic        ack_q, ack_d, zs_q, zs_d;

    // Round-to-nearest-even on normal operands; denormals are flushed to zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic              s, g, st;
        logic [47:0]       p;
        logic [24:0]       m;
        logic signed [9:0] e;
        s = x[31] ^ y[31];
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'd0};
        p = {1'b1, x[22:0]} * {1'b1, y[22:0]};
        e = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'sd127;
        if (p[47]) begin
            m = {1'b0, p[47:24]}; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
        end else begin
            m = {1'b0, p[46:23]}; g = p[22]; st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin m = m >> 1; e = e + 10'sd1; end
        if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
        if (e <= 10'sd0) return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]       p, q;
        logic [26:0]       mp, mq;
        logic [53:0]       t;
        logic [27:0]       s;
        logic [7:0]        d;
        logic [24:0]       m;
        logic              g, st;
        logic signed [9:0] e;
        int                sh;
        if (y[30:23] == 8'd0) return x;
        if (x[30:23] == 8'd0) return y;
        if (x[30:0] >= y[30:0]) begin p = x; q = y; end
        else begin p = y; q = x; end
        d  = p[30:23] - q[30:23];
        mp = {1'b1, p[22:0], 3'b000};
        if (d > 8'd26) mq = 27'd1;
        else begin
            t  = {1'b1, q[22:0], 3'b000, 27'd0} >> d;
            mq = t[53:27] | {26'd0, |t[26:0]};
        end
        s = (p[31] == q[31]) ? {1'b0, mp} + {1'b0, mq} : {1'b0, mp} - {1'b0, mq};
        if (s == 28'd0) return 32'h0;
        e = $signed({2'b00, p[30:23]});
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'sd1;
        end else begin
            sh = 0;
            for (int i = 0; i <= 26; i++) if (s[i]) sh = 26 - i;
            s = s << sh;
            e = e - $signed(10'(sh));
        end
        m = {1'b0, s[26:3]}; g = s[2]; st = |s[1:0];
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin m = m >> 1; e = e + 10'sd1; end
        if (e >= 10'sd255) return {p[31], 8'hFF, 23'd0};
        if (e <= 10'sd0) return {p[31], 31'd0};
        return {p[31], e[7:0], m[22:0]};
    endfunction

    always_comb begin
        st_d  = st_q;
        opa_d = opa_q;
        opb_d = opb_q;
        z_d   = z_q;
        ack_d = 1'b0;
        zs_d  = zs_q;
        case (st_q)
            U_IDLE: if (a_stb && b_stb) begin
                opa_d = a; opb_d = b; ack_d = 1'b1; st_d = U_CALC;
            end
            U_CALC: begin
                z_d  = IS_ADD ? fp_add(opa_q, opb_q) : fp_mul(opa_q, opb_q);
                zs_d = 1'b1;
                st_d = U_OUT;
            end
            U_OUT: if (z_ack) begin
                zs_d = 1'b0; st_d = U_IDLE;
            end
            default: st_d = U_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= U_IDLE; opa_q <= '0; opb_q <= '0; z_q <= '0; ack_q <= 1'b0; zs_q <= 1'b0;
        end else begin
            st_q <= st_d; opa_q <= opa_d; opb_q <= opb_d; z_q <= z_d; ack_q <= ack_d; zs_q <= zs_d;
        end
    end

    assign a_ack = ack_q;
    assign b_ack = ack_q;
    assign z     = z_q;
    assign z_stb = zs_q;
endmodule

module inner_product_acc #(
    parameter int number_of_elements = 4,
    parameter int LANES              = 2
) (
    input logic               clk,
    input logic               rst,
    inner_product_acc_if.slave bus
);
    localparam int N  = number_of_elements;
    localparam int NB = (LANES > 0) ? N / LANES : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [2:0] IDLE = 3'd0, MUL_ISSUE = 3'd1, MUL_WAIT = 3'd2,
                           ADD_ISSUE = 3'd3, ADD_WAIT = 3'd4, DONE = 3'd5;

    if (N < 1 || LANES < 1 || (N % LANES) != 0) begin : g_bad_cfg
        $error("inner_product_acc: LANES must divide number_of_elements (>= 1)");
    end

    logic [2:0]              state_q, state_d;
    logic [BW-1:0]           batch_q, batch_d;
    logic [KW-1:0]           k_q, k_d;
    logic [31:0]             acc_q, acc_d, out_q, out_d;
    logic                    out_stb_q, out_stb_d;
    logic [32*N-1:0]         a_vec_q, a_vec_d, b_vec_q, b_vec_d;
    logic [LANES-1:0]        mul_stb_q, mul_stb_d, mul_zack_q, mul_zack_d, mul_done_q, mul_done_d;
    logic [LANES-1:0][31:0]  prod_q, prod_d;
    logic                    add_stb_q, add_stb_d, add_zack_q, add_zack_d;

    logic [LANES-1:0]        mul_aack, mul_back, mul_zstb;
    logic [LANES-1:0][31:0]  mul_z;
    logic                    add_aack, add_back, add_zstb;
    logic [31:0]             add_z;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fp_unit #(.IS_ADD(1'b0)) u_mul (
            .clk   (clk),
            .rst   (rst),
            .a     (a_vec_q[32*(int'(batch_q)*LANES + l) +: 32]),
            .b     (b_vec_q[32*(int'(batch_q)*LANES + l) +: 32]),
            .a_stb (mul_stb_q[l]),
            .b_stb (mul_stb_q[l]),
            .a_ack (mul_aack[l]),
            .b_ack (mul_back[l]),
            .z     (mul_z[l]),
            .z_stb (mul_zstb[l]),
            .z_ack (mul_zack_q[l])
        );
    end

    fp_unit #(.IS_ADD(1'b1)) u_add (
        .clk   (clk),
        .rst   (rst),
        .a     (acc_q),
        .b     (prod_q[k_q]),
        .a_stb (add_stb_q),
        .b_stb (add_stb_q),
        .a_ack (add_aack),
        .b_ack (add_back),
        .z     (add_z),
        .z_stb (add_zstb),
        .z_ack (add_zack_q)
    );

    always_comb begin
        state_d    = state_q;
        batch_d    = batch_q;
        k_d        = k_q;
        acc_d      = acc_q;
        out_d      = out_q;
        out_stb_d  = out_stb_q;
        a_vec_d    = a_vec_q;
        b_vec_d    = b_vec_q;
        mul_stb_d  = mul_stb_q;
        mul_zack_d = '0;
        mul_done_d = mul_done_q;
        prod_d     = prod_q;
        add_stb_d  = add_stb_q;
        add_zack_d = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = MUL_ISSUE;
                batch_d = '0;
                acc_d   = bus.acc_en ? out_q : 32'h0;
                a_vec_d = bus.In1;
                b_vec_d = bus.In2;
            end
            MUL_ISSUE: begin
                mul_stb_d  = '1;
                mul_done_d = '0;
                state_d    = MUL_WAIT;
            end
            MUL_WAIT: begin
                for (int l = 0; l < LANES; l++) begin
                    if (mul_stb_q[l] && mul_aack[l] && mul_back[l]) mul_stb_d[l] = 1'b0;
                    if (mul_zstb[l] && !mul_done_q[l]) begin
                        prod_d[l]     = mul_z[l];
                        mul_done_d[l] = 1'b1;
                        mul_zack_d[l] = 1'b1;
                    end
                end
                if (&mul_done_d) begin
                    state_d = ADD_ISSUE;
                    k_d     = '0;
                end
            end
            ADD_ISSUE: begin
                add_stb_d = 1'b1;
                state_d   = ADD_WAIT;
            end
            ADD_WAIT: begin
                if (add_stb_q && add_aack && add_back) add_stb_d = 1'b0;
                if (add_zstb && !add_zack_q) begin
                    acc_d      = add_z;
                    add_zack_d = 1'b1;
                    if (k_q != KW'(LANES - 1)) begin
                        k_d     = k_q + KW'(1);
                        state_d = ADD_ISSUE;
                    end else if (batch_q == BW'(NB - 1)) begin
                        out_d     = add_z;
                        out_stb_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        batch_d = batch_q + BW'(1);
                        state_d = MUL_ISSUE;
                    end
                end
            end
            DONE: if (bus.out_ack) begin
                out_stb_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;     batch_q <= '0;    k_q <= '0;
            acc_q <= '0;         out_q <= '0;      out_stb_q <= 1'b0;
            a_vec_q <= '0;       b_vec_q <= '0;
            mul_stb_q <= '0;     mul_zack_q <= '0; mul_done_q <= '0; prod_q <= '0;
            add_stb_q <= 1'b0;   add_zack_q <= 1'b0;
        end else begin
            state_q <= state_d;     batch_q <= batch_d;       k_q <= k_d;
            acc_q <= acc_d;         out_q <= out_d;           out_stb_q <= out_stb_d;
            a_vec_q <= a_vec_d;     b_vec_q <= b_vec_d;
            mul_stb_q <= mul_stb_d; mul_zack_q <= mul_zack_d; mul_done_q <= mul_done_d; prod_q <= prod_d;
            add_stb_q <= add_stb_d; add_zack_q <= add_zack_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.out     = out_q;
    assign bus.out_stb = out_stb_q;
endmodule

// File: tb/tb_inner_product_acc.sv
// tb/tb_inner_product_acc.sv - scoreboard bench running LANES=1/2/4 instances in lockstep
module tb_inner_product_acc;
    localparam logic [127:0] VA   = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    localparam logic [127:0] VB   = {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000};
    localparam logic [127:0] V2   = {4{32'h40000000}};
    localparam logic [127:0] VH   = {4{32'hBF000000}};
    localparam logic [127:0] VZ   = '0;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] exp_q[$];

    inner_product_acc_if #(.number_of_elements(4)) if1 ();
    inner_product_acc_if #(.number_of_elements(4)) if2 ();
    inner_product_acc_if #(.number_of_elements(4)) if4 ();

    inner_product_acc #(.number_of_elements(4), .LANES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    inner_product_acc #(.number_of_elements(4), .LANES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    inner_product_acc #(.number_of_elements(4), .LANES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    assign if1.start = if2.start;   assign if4.start = if2.start;
    assign if1.acc_en = if2.acc_en; assign if4.acc_en = if2.acc_en;
    assign if1.In1 = if2.In1;       assign if4.In1 = if2.In1;
    assign if1.In2 = if2.In2;       assign if4.In2 = if2.In2;
    assign if1.out_ack = if2.out_ack; assign if4.out_ack = if2.out_ack;

    logic [31:0] outs [3];
    logic [2:0]  stbs, busys;
    assign outs[0] = if1.out;
    assign outs[1] = if2.out;
    assign outs[2] = if4.out;
    assign stbs  = {if4.out_stb, if2.out_stb, if1.out_stb};
    assign busys = {if4.busy, if2.busy, if1.busy};

    always #5 clk = ~clk;

    task automatic start_op(input logic [127:0] a, input logic [127:0] b, input logic en,
                            input logic [31:0] exp, input bit push);
        if2.In1 = a; if2.In2 = b; if2.acc_en = en; if2.start = 1'b1;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        if2.start = 1'b0;
    endtask

    task automatic wait_all(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (&stbs) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busys !== 3'b000) begin miscompares++; $display("FAIL reset_busy got %b want 000", busys); end
        vectors++;
        if (stbs !== 3'b000) begin miscompares++; $display("FAIL reset_out_stb got %b want 000", stbs); end
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (outs[d] !== 32'h0) begin miscompares++; $display("FAIL reset_out[%0d] got %h want 00000000", d, outs[d]); end
        end
    endtask

    task automatic test_dot_product(input string name, input logic [127:0] a, input logic [127:0] b,
                                    input logic en, input logic [31:0] exp);
        bit          ok;
        logic [31:0] want;
        start_op(a, b, en, exp, 1'b1);
        vectors++;
        if (busys !== 3'b111) begin miscompares++; $display("FAIL %s_busy got %b want 111", name, busys); end
        wait_all(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL %s_timeout out_stb got %b want 111", name, stbs); end
        want = exp_q.pop_front();
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (outs[d] !== want) begin miscompares++; $display("FAIL %s_out[%0d] got %h want %h", name, d, outs[d], want); end
        end
        if2.out_ack = 1'b1;
        @(negedge clk);
        if2.out_ack = 1'b0;
        vectors++;
        if ({busys, stbs} !== 6'b0) begin miscompares++; $display("FAIL %s_release busy/stb got %b/%b want 000/000", name, busys, stbs); end
    endtask

    task automatic test_hold;
        bit          ok;
        logic [31:0] want;
        start_op(VA, VB, 1'b0, 32'h428C0000, 1'b1);
        wait_all(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL hold_timeout out_stb got %b want 111", stbs); end
        want = exp_q.pop_front();
        if2.In1 = VZ; if2.In2 = VZ; if2.acc_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if2.start = (c % 3) == 0;
            vectors++;
            if (stbs !== 3'b111 || busys !== 3'b111) begin
                miscompares++; $display("FAIL hold_stb cycle %0d stb/busy got %b/%b want 111/111", c, stbs, busys);
            end
            for (int d = 0; d < 3; d++) begin
                vectors++;
                if (outs[d] !== want) begin miscompares++; $display("FAIL hold_out[%0d] cycle %0d got %h want %h", d, c, outs[d], want); end
            end
            @(negedge clk);
        end
        if2.start = 1'b0;
        if2.out_ack = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busys, stbs} !== 6'b0) begin miscompares++; $display("FAIL hold_release busy/stb got %b/%b want 000/000", busys, stbs); end
        repeat (3) @(negedge clk);
        if2.out_ack = 1'b0;
        vectors++;
        if ({busys, stbs} !== 6'b0) begin miscompares++; $display("FAIL idle_ack busy/stb got %b/%b want 000/000", busys, stbs); end
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (outs[d] !== want) begin miscompares++; $display("FAIL idle_out[%0d] got %h want %h", d, outs[d], want); end
        end
    endtask

    task automatic test_reset_midop;
        start_op(VA, VB, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busys, stbs} !== 6'b0) begin miscompares++; $display("FAIL midrst busy/stb got %b/%b want 000/000", busys, stbs); end
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (outs[d] !== 32'h0) begin miscompares++; $display("FAIL midrst_out[%0d] got %h want 00000000", d, outs[d]); end
        end
        repeat (30) @(negedge clk);
        vectors++;
        if ({busys, stbs} !== 6'b0) begin miscompares++; $display("FAIL midrst_quiet busy/stb got %b/%b want 000/000", busys, stbs); end
        test_dot_product("after_rst", VA, VB, 1'b0, 32'h428C0000);
    endtask

    task automatic test_operand_latch;
        bit          ok;
        logic [31:0] want;
        start_op(VA, VB, 1'b0, 32'h428C0000, 1'b1);
        if2.In1 = VZ; if2.In2 = VZ;
        wait_all(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL latch_timeout out_stb got %b want 111", stbs); end
        want = exp_q.pop_front();
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (outs[d] !== want) begin miscompares++; $display("FAIL latch_out[%0d] got %h want %h", d, outs[d], want); end
        end
        if2.out_ack = 1'b1;
        @(negedge clk);
        if2.out_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if2.start = 1'b0; if2.acc_en = 1'b0; if2.In1 = '0; if2.In2 = '0; if2.out_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_dot_product("t1_basic", VA, VB, 1'b0, 32'h428C0000);
        test_dot_product("t2_chain", VA, VB, 1'b1, 32'h430C0000);
        test_dot_product("t3_neg", V2, VH, 1'b0, 32'hC0800000);
        test_dot_product("chain_neg", VA, VB, 1'b1, 32'h42840000);
        test_hold();
        test_reset_midop();
        test_operand_latch();
        test_dot_product("after_rst_chain", V2, VH, 1'b1, 32'h42840000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
